// File: rtl/ddr3_axi_rd_bridge.sv
// AXI-style read slave to DDR3 read-port bridge.
// Wide DDR beats are split into narrow slave beats. Every burst checks the
// window and the burst type. DDR requests are credit-limited, so the data
// FIFO can never overflow.
module ddr3_axi_rd_bridge #(
  parameter logic [31:0] OFFSET_ADDR  = 32'h00000000,
  parameter logic [31:0] WINDOW_WORDS = 32'h10000000,
  parameter int unsigned S_DW         = 32,
  parameter int unsigned M_DW         = 256,
  parameter int unsigned M_AW         = 28,
  parameter int unsigned ID_W         = 4,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   SLAVE_RD_ADDR_ID,
  input  logic [31:0]       SLAVE_RD_ADDR,
  input  logic [7:0]        SLAVE_RD_ADDR_LEN,
  input  logic [1:0]        SLAVE_RD_ADDR_BURST,
  input  logic              SLAVE_RD_ADDR_VALID,
  output logic              SLAVE_RD_ADDR_READY,
  output logic [ID_W-1:0]   SLAVE_RD_BACK_ID,
  output logic [S_DW-1:0]   SLAVE_RD_DATA,
  output logic [1:0]        SLAVE_RD_DATA_RESP,
  output logic              SLAVE_RD_DATA_LAST,
  output logic              SLAVE_RD_DATA_VALID,
  input  logic              SLAVE_RD_DATA_READY,
  output logic [M_AW-1:0]   READ_ADDR,
  output logic [3:0]        READ_LEN,
  output logic [ID_W-1:0]   READ_ID,
  output logic              READ_ADDR_VALID,
  input  logic              READ_ADDR_READY,
  input  logic [M_DW-1:0]   READ_DATA,
  input  logic [ID_W-1:0]   READ_BACK_ID,
  input  logic              READ_DATA_LAST,
  input  logic              READ_DATA_VALID
);

  localparam int unsigned R  = M_DW / S_DW;
  localparam int unsigned LR = $clog2(R);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;
  state_t state, state_nxt;

  logic              alive;
  logic [ID_W-1:0]   cap_id;
  logic [7:0]        cap_len;
  logic [1:0]        cap_resp;
  logic [8:0]        beat_cnt;
  logic              all_loaded;
  logic [8:0]        req_left;
  logic [M_AW-1:0]   next_addr;
  logic [LR-1:0]     word_idx;
  logic [M_DW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, pending, fifo_cnt_nxt, pending_nxt;

  logic [31:0]       conv, credit, chunk;
  logic [32:0]       conv_end;
  logic [1:0]        resp_nxt;
  logic [8:0]        n_beats;
  logic [S_DW-1:0]   head_word;
  logic              addr_hs, issue, load, pop, push, out_hs, final_beat;
  logic              unused_ok;

  assign unused_ok  = ^{READ_BACK_ID, READ_DATA_LAST, conv};

  assign SLAVE_RD_ADDR_READY = alive && (state == IDLE);
  assign addr_hs    = SLAVE_RD_ADDR_READY && SLAVE_RD_ADDR_VALID;
  assign conv       = SLAVE_RD_ADDR - OFFSET_ADDR;
  assign conv_end   = {1'b0, conv} + {25'd0, SLAVE_RD_ADDR_LEN};
  assign n_beats    = 9'(({1'b0, SLAVE_RD_ADDR_LEN} + 9'(conv[LR-1:0])) >> LR) + 9'd1;
  assign credit     = 32'(FIFO_DEPTH) - 32'(fifo_cnt) - 32'(pending);
  assign issue      = (state == RUN) && !READ_ADDR_VALID && (req_left != '0) && (credit != '0);
  assign out_hs     = SLAVE_RD_DATA_VALID && SLAVE_RD_DATA_READY;
  assign final_beat = (beat_cnt == {1'b0, cap_len});
  assign load       = (((state == RUN) && (fifo_cnt != '0)) || (state == ERR)) &&
                      !all_loaded && (!SLAVE_RD_DATA_VALID || SLAVE_RD_DATA_READY);
  assign pop        = load && (state == RUN) && ((word_idx == LR'(R - 1)) || final_beat);
  assign push       = READ_DATA_VALID;
  assign head_word  = mem[rd_ptr][int'(word_idx)*S_DW +: S_DW];

  // Burst classification and DDR chunk sizing (remaining, 16, credit)
  always_comb begin
    resp_nxt = 2'b00;
    if (SLAVE_RD_ADDR_BURST != 2'b01)             resp_nxt = 2'b10;
    else if (conv_end >= {1'b0, WINDOW_WORDS})    resp_nxt = 2'b11;
    chunk = 32'(req_left);
    if (chunk > 32'd16)  chunk = 32'd16;
    if (chunk > credit)  chunk = credit;
    fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
    pending_nxt  = pending - CW'(push);
    if (issue) pending_nxt = pending_nxt + CW'(chunk);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (addr_hs) state_nxt = (resp_nxt == 2'b00) ? RUN : ERR;
      RUN,
      ERR:     if (out_hs && SLAVE_RD_DATA_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage, written on every DDR data beat
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= READ_DATA;
  end

  // State, capture, DDR request issue, FIFO pointers and slave output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= IDLE;
      alive               <= 1'b0;
      cap_id              <= '0;
      cap_len             <= '0;
      cap_resp            <= '0;
      beat_cnt            <= '0;
      all_loaded          <= 1'b0;
      req_left            <= '0;
      next_addr           <= '0;
      word_idx            <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      pending             <= '0;
      READ_ADDR           <= '0;
      READ_LEN            <= '0;
      READ_ID             <= '0;
      READ_ADDR_VALID     <= 1'b0;
      SLAVE_RD_BACK_ID    <= '0;
      SLAVE_RD_DATA       <= '0;
      SLAVE_RD_DATA_RESP  <= '0;
      SLAVE_RD_DATA_LAST  <= 1'b0;
      SLAVE_RD_DATA_VALID <= 1'b0;
    end else begin
      alive    <= 1'b1;
      state    <= state_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      pending  <= pending_nxt;
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

      if (addr_hs) begin
        cap_id     <= SLAVE_RD_ADDR_ID;
        cap_len    <= SLAVE_RD_ADDR_LEN;
        cap_resp   <= resp_nxt;
        beat_cnt   <= '0;
        all_loaded <= 1'b0;
        word_idx   <= conv[LR-1:0];
        next_addr  <= {conv[M_AW-1:LR], {LR{1'b0}}};
        req_left   <= (resp_nxt == 2'b00) ? n_beats : '0;
      end

      if (issue) begin
        READ_ADDR_VALID <= 1'b1;
        READ_ADDR       <= next_addr;
        READ_LEN        <= 4'(chunk - 32'd1);
        READ_ID         <= cap_id;
        next_addr       <= next_addr + M_AW'(chunk << LR);
        req_left        <= req_left - 9'(chunk);
      end else if (READ_ADDR_VALID && READ_ADDR_READY) begin
        READ_ADDR_VALID <= 1'b0;
      end

      if (load) begin
        SLAVE_RD_DATA_VALID <= 1'b1;
        SLAVE_RD_DATA       <= (state == ERR) ? '0 : head_word;
        SLAVE_RD_DATA_RESP  <= cap_resp;
        SLAVE_RD_DATA_LAST  <= final_beat;
        SLAVE_RD_BACK_ID    <= cap_id;
        beat_cnt            <= beat_cnt + 9'd1;
        if (final_beat) all_loaded <= 1'b1;
        if (state == RUN) word_idx <= pop ? '0 : word_idx + LR'(1);
      end else if (out_hs) begin
        SLAVE_RD_DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ddr3_axi_rd_bridge.md
DDR3_AXI_RD_BRIDGE -- requirements
Module: ddr3_axi_rd_bridge

Interface
REQ-001 SHALL have parameter OFFSET_ADDR, default 32'h00000000, subtracted from every incoming slave address.
REQ-002 SHALL have parameter WINDOW_WORDS, default 32'h10000000, the legal window size in S_DW-words.
REQ-003 SHALL have parameters S_DW (32) and M_DW (256), slave and DDR data widths; R = M_DW/S_DW, a power of two >= 2.
REQ-004 SHALL have parameters M_AW (28), DDR address width in S_DW-words; ID_W (4), ID width; FIFO_DEPTH (32), M_DW entries, >= 16.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rstn  in  1  async active-low reset.
REQ-006 Slave address ports: SLAVE_RD_ADDR_ID in ID_W; SLAVE_RD_ADDR in 32; SLAVE_RD_ADDR_LEN in 8 (beats-1); SLAVE_RD_ADDR_BURST in 2; SLAVE_RD_ADDR_VALID in 1; SLAVE_RD_ADDR_READY out 1.
REQ-007 Slave data ports: SLAVE_RD_BACK_ID out ID_W; SLAVE_RD_DATA out S_DW; SLAVE_RD_DATA_RESP out 2; SLAVE_RD_DATA_LAST out 1; SLAVE_RD_DATA_VALID out 1; SLAVE_RD_DATA_READY in 1.
REQ-008 DDR address ports: READ_ADDR out M_AW; READ_LEN out 4 (beats-1); READ_ID out ID_W; READ_ADDR_VALID out 1; READ_ADDR_READY in 1.
REQ-009 DDR data ports: READ_DATA in M_DW; READ_BACK_ID in ID_W (ignored); READ_DATA_LAST in 1 (ignored); READ_DATA_VALID in 1 (no back-pressure possible).

Function
REQ-010 FSM states IDLE, RUN, ERR; SLAVE_RD_ADDR_READY SHALL be 1 only in IDLE; exactly one burst outstanding at a time.
REQ-011 On address handshake: capture ID and LEN; conv = ADDR - OFFSET_ADDR (32-bit wrap); BURST != 2'b01 -> resp 2'b10, ERR; else conv+LEN >= WINDOW_WORDS (33-bit compare) -> resp 2'b11, ERR; else resp 2'b00, RUN.
REQ-012 ERR: emit LEN+1 beats, DATA=0, RESP=captured error code, LAST on final beat, no DDR request; then IDLE.
REQ-013 RUN: off = conv[log2R-1:0]; first DDR address = conv with low log2R bits cleared; total DDR beats N = ((off+LEN)>>log2R)+1.
REQ-014 Requests SHALL split into chunks of min(remaining, 16, free credit) beats; READ_ADDR advances by chunk*R per chunk; READ_ID = captured ID.
REQ-015 Credit = FIFO_DEPTH - (occupancy + beats requested but not yet received); a chunk SHALL NOT be issued unless it fits, so READ_DATA_VALID never hits a full FIFO.
REQ-016 READ_ADDR_VALID SHALL rise no earlier than the cycle after the slave handshake; ADDR/LEN/VALID held stable until READ_ADDR_READY.
REQ-017 Every READ_DATA_VALID cycle SHALL push READ_DATA into the FIFO.
REQ-018 Serializer: first slave word is FIFO head word off; words are taken LSB-first at S_DW*i; a FIFO entry pops after word R-1 or after the final slave beat; unused trailing words are discarded.
REQ-019 Slave data output SHALL be a registered stage: DATA/RESP/LAST/BACK_ID stable while VALID=1 and READY=0; one beat per cycle at full throughput with READY held 1.
REQ-020 SLAVE_RD_DATA_LAST SHALL be 1 exactly on beat LEN+1; RUN/ERR -> IDLE in the cycle after that beat's handshake.
REQ-021 LEN=0 SHALL give one beat; off+LEN crossing a DDR-word boundary SHALL request the extra DDR beat.
REQ-022 SLAVE_RD_BACK_ID SHALL equal the captured ID on every beat of the burst.

Reset
REQ-023 rstn low SHALL immediately force state IDLE, FIFO empty, credit full, all VALID/LAST/READY outputs 0, DATA/ADDR/LEN/ID/RESP 0; any in-flight burst is abandoned.
REQ-024 First rising clk after rstn release SHALL set SLAVE_RD_ADDR_READY=1.

Verification
REQ-025 ADDR=OFFSET+0, LEN=7, BURST=01 -> one DDR request ADDR=0 LEN=0; 8 beats = words 0..7 of READ_DATA, RESP=00, LAST on beat 8.
REQ-026 ADDR=OFFSET+5, LEN=3 -> DDR ADDR=0 LEN=1; beats = words 5,6,7 of DDR beat 0 then word 0 of DDR beat 1.
REQ-027 ADDR=OFFSET, LEN=255, FIFO_DEPTH=16, READY toggling 50% -> first request LEN=15 only; further chunks only on credit; 32 DDR beats; no FIFO overflow; 256 beats in order.
REQ-028 ADDR=OFFSET+WINDOW_WORDS-2, LEN=3 -> RESP=11 on 4 zero beats, no READ_ADDR_VALID; then BURST=10 -> RESP=10 burst.
REQ-029 rstn pulsed low mid-RUN (after 3 of 8 beats) -> all outputs 0 asynchronously; READY=1 one clock after release; next burst correct.
